axil_cmd_seq: RTL and testbench
===============================

Name: axil_cmd_seq

Overview:
- AXI-Lite master that configures the peripheral subsystem (UART, SPI, I2C, RGMII slaves behind the crossbar) without a CPU.
- Fetches commands from an external synchronous ROM: register write, poll-until-match, delay, end.
- Connects to one crossbar master slot. Used for boot-time PHY/peripheral init and scripted self-test.

Parameters:
- AXIL_ADDR_WIDTH, 32, AXI-Lite address width.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width.
- CMD_DEPTH, 256, number of ROM entries; CMD_AW = $clog2(CMD_DEPTH).
- POLL_TIMEOUT, 65536, max poll reads before error (used only with AXIL_CMD_SEQ_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse; starts execution at ROM entry 0 when idle; ignored while busy_o=1.
- cmd_addr_o  out  CMD_AW  ROM read address.
- cmd_i  in  2+AXIL_ADDR_WIDTH+2*AXIL_DATA_WIDTH  ROM word {op[1:0], addr, data, mask}, valid 1 cycle after cmd_addr_o.
- busy_o  out  1  high from accepted start until DONE/ERR.
- done_o  out  1  one-cycle pulse on END executed.
- err_o  out  1  sticky; set on nonzero BRESP/RRESP or poll timeout; cleared by next accepted start_i.
- err_pc_o  out  CMD_AW  index of the failing command, valid while err_o=1.
- m_axil_aw*/w*/b*/ar*/r*  AXI-Lite master channels: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready; widths per parameters; awprot/arprot tied 0; wstrb all ones.

Behaviour:
- Reset: state IDLE, pc=0, cmd_addr_o=0, busy_o=0, done_o=0, err_o=0, err_pc_o=0, all valid/ready outputs 0.
- Opcodes:
  - 0 WRITE: addr←data.
  - 1 POLL: read addr repeatedly until (rdata & mask)==(data & mask).
  - 2 DELAY: wait data cycles; 0 means no wait.
  - 3 END: finish.
- States: IDLE, FETCH, DECODE, WR, WR_RESP, RD, RD_RESP, DELAY, DONE, ERR.
- IDLE:
  - start_i → pc=0, clear err_o, busy_o=1, → FETCH.
- FETCH:
  - Drive cmd_addr_o=pc; next cycle → DECODE and latch cmd_i.
- DECODE, per opcode:
  - WRITE → WR.
  - POLL → RD.
  - DELAY → DELAY with counter=data; data=0 goes straight to next fetch.
  - END → DONE.
- WR:
  - Assert awvalid and wvalid in the same cycle.
  - Each valid drops independently the cycle after its own handshake; AW and W may complete in either order or together.
  - Both complete → WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: bresp≠0 → ERR, otherwise pc+1 → FETCH.
- RD:
  - arvalid until arready → RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: rresp≠0 → ERR.
  - Match → pc+1 → FETCH.
  - Mismatch → RD; the same command is re-issued and the ROM is not re-fetched.
- DELAY:
  - Decrement each cycle; at 1 → pc+1 → FETCH.
  - Total cycles in DELAY = data.
- DONE: done_o=1 for one cycle, busy_o=0 → IDLE.
- ERR: err_o=1, err_pc_o=pc, busy_o=0 → IDLE.
- pc wrap: pc at CMD_DEPTH-1 with non-END op → ERR; pc never wraps.
- Valid stability: no valid deasserts before its handshake.
- Reset mid-transaction: all valids drop immediately; no outstanding-transaction tracking is required.
- start_i in the same cycle as DONE/ERR is ignored; a start is accepted only in IDLE.
- Latency: min WRITE = FETCH(1)+DECODE(1)+AW/W(≥1)+B(≥1) cycles.

Optional Feature:
- Macro AXIL_CMD_SEQ_TIMEOUT_EN.
- Defined:
  - A poll counter resets on each POLL decode and increments per mismatching read.
  - Reaching POLL_TIMEOUT mismatches → ERR with err_pc_o=pc.
- Undefined: POLL retries forever; no counter logic is synthesized.

Test Plan:
- ROM {WRITE 0x0000_0010←0xA5, END}, slave ready immediately → one AW/W at 0x10 data 0xA5, done_o pulses once, err_o=0, busy_o low after DONE.
- WRITE with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles, exactly one B accepted.
- POLL addr 0x20 data 0x1 mask 0x1, slave returns 0,0,0,1 → four AR transactions, then next command fetched.
- DELAY 10 followed by WRITE → AW asserted exactly 10+2 cycles after DELAY decode; DELAY 0 adds no DELAY cycle.
- WRITE returning bresp=2 at pc=3 → err_o=1, err_pc_o=3, no done_o; next start_i clears err_o and restarts at pc=0.
- With AXIL_CMD_SEQ_TIMEOUT_EN, POLL_TIMEOUT=4, never-matching slave → 4 reads, then err_o=1; reset asserted mid-RD clears arvalid next cycle.

Source files
------------

// File: rtl/axil_cmd_seq.sv
// axil_cmd_seq: ROM-driven AXI-Lite master that runs WRITE/POLL/DELAY/END
// scripts for boot-time peripheral setup without a CPU.
// Ports: clk_i/rst_i (sync, active high), start_i, ROM port
// (cmd_addr_o -> cmd_i, one cycle latency), busy_o/done_o/err_o/err_pc_o
// status, and one AXI-Lite master (m_axil_aw/w/b/ar/r channels).
// ROM word: {op[1:0], addr, data, mask}; op 0 WRITE, 1 POLL, 2 DELAY, 3 END.
// Optional macro AXIL_CMD_SEQ_TIMEOUT_EN: a POLL errors out after
// POLL_TIMEOUT mismatching reads; without it a POLL retries forever.
module axil_cmd_seq #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int CMD_DEPTH       = 256,
  parameter int POLL_TIMEOUT    = 65536,
  localparam int CMD_AW = $clog2(CMD_DEPTH),
  localparam int CMD_W  = 2 + AXIL_ADDR_WIDTH + 2 * AXIL_DATA_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic [CMD_AW-1:0]            cmd_addr_o,
  input  logic [CMD_W-1:0]             cmd_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [CMD_AW-1:0]            err_pc_o,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]                   m_axil_awprot,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]                   m_axil_arprot,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready
);

  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR, S_WR_RESP,
    S_RD, S_RD_RESP, S_DELAY, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;
  localparam logic [CMD_AW-1:0] PC_LAST = CMD_AW'(CMD_DEPTH - 1);

  state_t            state_q, state_d;
  logic [CMD_AW-1:0] pc_q, pc_d;
  logic [CMD_AW-1:0] err_pc_q, err_pc_d;
  logic              err_q, err_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     mask_q, mask_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              awv_q, awv_d;
  logic              wv_q, wv_d;
  logic              arv_q, arv_d;

  logic [1:0]    f_op;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic [DW-1:0] f_mask;
  logic          aw_hs, w_hs, fail, rd_match;

  assign {f_op, f_addr, f_data, f_mask} = cmd_i;

`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
  localparam int PTW = $clog2(POLL_TIMEOUT + 1);
  logic [PTW-1:0] poll_q, poll_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_pc_d = err_pc_q;
    err_d    = err_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    dly_d    = dly_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    arv_d    = arv_q;
    fail     = 1'b0;
    aw_hs    = awv_q & m_axil_awready;
    w_hs     = wv_q & m_axil_wready;
    rd_match = (m_axil_rdata & mask_q) == (data_q & mask_q);
`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
    poll_d   = poll_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        addr_d = f_addr;
        data_d = f_data;
        mask_d = f_mask;
        // pc never wraps: only END may sit in the last slot
        if (f_op != OP_END && pc_q == PC_LAST) begin
          fail = 1'b1;
        end else begin
          unique case (f_op)
            OP_WRITE: begin
              awv_d   = 1'b1;
              wv_d    = 1'b1;
              state_d = S_WR;
            end
            OP_POLL: begin
              arv_d   = 1'b1;
              state_d = S_RD;
`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
              poll_d  = '0;
`endif
            end
            OP_DELAY: begin
              if (f_data == '0) begin
                pc_d    = pc_q + 1'b1;
                state_d = S_FETCH;
              end else begin
                dly_d   = f_data;
                state_d = S_DELAY;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_WR: begin
        if (aw_hs) awv_d = 1'b0;
        if (w_hs)  wv_d  = 1'b0;
        if ((aw_hs || !awv_q) && (w_hs || !wv_q))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          if (m_axil_bresp != 2'b00) begin
            fail = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_RD: begin
        if (m_axil_arready) begin
          arv_d   = 1'b0;
          state_d = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axil_rvalid) begin
          if (m_axil_rresp != 2'b00) begin
            fail = 1'b1;
          end else if (rd_match) begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
          end else if (poll_q == PTW'(POLL_TIMEOUT - 1)) begin
            fail = 1'b1;
`endif
          end else begin
            // re-issue from latched command, no ROM re-fetch
            arv_d   = 1'b1;
            state_d = S_RD;
`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
            poll_d  = poll_q + 1'b1;
`endif
          end
        end
      end
      S_DELAY: begin
        if (dly_q == DW'(1)) begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      err_d    = 1'b1;
      err_pc_d = pc_q;
      state_d  = S_ERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      err_pc_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      dly_q    <= '0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      arv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_pc_q <= err_pc_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      dly_q    <= dly_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      arv_q    <= arv_d;
    end
  end

`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) poll_q <= '0;
    else       poll_q <= poll_d;
  end
`endif

  assign cmd_addr_o     = pc_q;
  assign busy_o         = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done_o         = state_q == S_DONE;
  assign err_o          = err_q;
  assign err_pc_o       = err_pc_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awv_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wv_q;
  assign m_axil_bready  = state_q == S_WR_RESP;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arv_q;
  assign m_axil_rready  = state_q == S_RD_RESP;

endmodule

// File: tb/tb_axil_cmd_seq.sv
// tb_axil_cmd_seq: scenario tasks against a ROM model, an AXI-Lite slave
// with configurable ready latency, and a program-level reference model.
module tb_axil_cmd_seq;

  localparam int DEPTH = 16;
  localparam int CW    = 98;

  logic          clk = 0;
  logic          rst_i = 1;
  logic          start_i = 0;
  logic [3:0]    cmd_addr;
  logic [CW-1:0] cmd_i = '0;
  logic          busy, done, err;
  logic [3:0]    err_pc;
  logic [31:0]   awaddr, wdata, araddr;
  logic [31:0]   rdata = 0;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic          awready = 0, wready = 0, arready = 0;
  logic          bvalid = 0, rvalid = 0;
  logic [1:0]    bresp = 0, rresp = 0;

  axil_cmd_seq #(
    .AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32),
    .CMD_DEPTH(DEPTH), .POLL_TIMEOUT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .cmd_addr_o(cmd_addr), .cmd_i(cmd_i),
    .busy_o(busy), .done_o(done), .err_o(err), .err_pc_o(err_pc),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] rom [DEPTH];
  always @(posedge clk) cmd_i <= rom[cmd_addr];

  int n_chk = 0;
  int n_fail = 0;

  // slave configuration
  int aw_hold = 1, w_hold = 1, ar_hold = 1, err_b_idx = -1;
  logic [31:0] rd_seq[$];
  // slave / monitor state
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int aw_cnt, w_cnt, ar_cnt, aw_pend, w_pend, r_pend, b_idx;
  int awv_cyc, wv_cyc, b_cnt, done_cnt, viol, cyc;
  int busy_rise, first_aw;
  bit aw_hs, w_hs, ar_hs, b_hs, r_hs, busy_p;
  bit awv_p, wv_p, arv_p;
  logic [31:0] awa_p, wd_p, ara_p;

  // Ready/response decisions are made at negedge for the coming posedge,
  // so a handshake is valid && (newly chosen) ready at this point.
  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0; bresp = 0; rresp = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_pend = 0; w_pend = 0; r_pend = 0; b_idx = 0;
      awv_cyc = 0; wv_cyc = 0; b_cnt = 0; done_cnt = 0; viol = 0;
      busy_rise = -1; first_aw = -1;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; busy_p = 0;
      awv_p = 0; wv_p = 0; arv_p = 0;
      aw_log.delete(); w_log.delete(); ar_log.delete();
    end else begin
      if (aw_hs) aw_pend++;
      if (w_hs) w_pend++;
      if (ar_hs) r_pend++;
      if (b_hs) bvalid = 0;
      if (r_hs) rvalid = 0;
      if (awv_p && !aw_hs && (!awvalid || awaddr != awa_p)) viol++;
      if (wv_p && !w_hs && (!wvalid || wdata != wd_p)) viol++;
      if (arv_p && !ar_hs && (!arvalid || araddr != ara_p)) viol++;
      if (awvalid) begin
        if (first_aw < 0) first_aw = cyc;
        awv_cyc++;
        awready = aw_cnt >= aw_hold - 1;
        aw_cnt++;
      end else begin
        awready = 0; aw_cnt = 0;
      end
      if (wvalid) begin
        wv_cyc++;
        wready = w_cnt >= w_hold - 1;
        w_cnt++;
        if (wstrb != 4'hf) viol++;
      end else begin
        wready = 0; w_cnt = 0;
      end
      if (arvalid) begin
        arready = ar_cnt >= ar_hold - 1;
        ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      if (aw_hs) aw_log.push_back(awaddr);
      if (w_hs) w_log.push_back(wdata);
      if (ar_hs) ar_log.push_back(araddr);
      if (!bvalid && aw_pend > 0 && w_pend > 0) begin
        bvalid = 1;
        bresp = (b_idx == err_b_idx) ? 2'd2 : 2'd0;
        b_idx++; aw_pend--; w_pend--;
      end
      if (!rvalid && r_pend > 0) begin
        rvalid = 1;
        rdata = (rd_seq.size() > 0) ? rd_seq.pop_front() : 32'h0;
        rresp = 0;
        r_pend--;
      end
      b_hs = bvalid && bready;
      r_hs = rvalid && rready;
      if (b_hs) b_cnt++;
      if (done) done_cnt++;
      if (busy && !busy_p) busy_rise = cyc;
      busy_p = busy;
      awv_p = awvalid; wv_p = wvalid; arv_p = arvalid;
      awa_p = awaddr; wd_p = wdata; ara_p = araddr;
    end
  end

  function automatic logic [CW-1:0] mk(input logic [1:0] op,
    input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    return {op, a, d, m};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(2'd3, 0, 0, 0);
  endtask

  task automatic do_reset();
    start_i = 0;
    rst_i = 1;
    repeat (2) @(negedge clk);
    rst_i = 0;
    aw_hold = 1; w_hold = 1; ar_hold = 1; err_b_idx = -1;
    rd_seq.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
  endtask

  task automatic wait_idle(input int limit, output bit tmo);
    int n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    tmo = busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rom_clear();
    do_reset();
    n_chk++; if (busy !== 0 || done !== 0) begin n_fail++;
      $display("FAIL reset busy/done: got %b/%b exp 0/0", busy, done); end
    n_chk++; if (err !== 0 || err_pc !== 0) begin n_fail++;
      $display("FAIL reset err: got %b pc %0d exp 0/0", err, err_pc); end
    n_chk++; if (cmd_addr !== 0) begin n_fail++;
      $display("FAIL reset cmd_addr: got %0d exp 0", cmd_addr); end
    n_chk++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset valids: got %b exp 00000",
        {awvalid, wvalid, arvalid, bready, rready}); end
  endtask

  task automatic test_single_write();
    bit tmo;
    rom_clear();
    rom[0] = mk(2'd0, 32'h10, 32'hA5, 0);
    do_reset();
    pulse_start();
    wait_idle(200, tmo);
    n_chk++; if (tmo) begin n_fail++;
      $display("FAIL wr1 timeout: busy stuck got 1 exp 0"); end
    n_chk++; if (aw_log.size() != 1 || w_log.size() != 1) begin n_fail++;
      $display("FAIL wr1 count: got %0d/%0d exp 1/1",
        aw_log.size(), w_log.size()); end
    else begin
      n_chk++; if (aw_log[0] !== 32'h10 || w_log[0] !== 32'hA5) begin
        n_fail++; $display("FAIL wr1 payload: got %h/%h exp 10/a5",
          aw_log[0], w_log[0]); end
    end
    n_chk++; if (done_cnt != 1 || err !== 0 || busy !== 0) begin n_fail++;
      $display("FAIL wr1 status: got done %0d err %b busy %b exp 1/0/0",
        done_cnt, err, busy); end
  endtask

  task automatic test_aw_delay();
    bit tmo;
    rom_clear();
    rom[0] = mk(2'd0, 32'h44, 32'h1234, 0);
    do_reset();
    aw_hold = 3;
    pulse_start();
    wait_idle(200, tmo);
    n_chk++; if (tmo) begin n_fail++;
      $display("FAIL awdly timeout: busy stuck got 1 exp 0"); end
    n_chk++; if (awv_cyc != 3 || wv_cyc != 1) begin n_fail++;
      $display("FAIL awdly valid cycles: got aw %0d w %0d exp 3/1",
        awv_cyc, wv_cyc); end
    n_chk++; if (b_cnt != 1 || done_cnt != 1) begin n_fail++;
      $display("FAIL awdly b/done: got %0d/%0d exp 1/1", b_cnt, done_cnt); end
  endtask

  task automatic test_poll();
    bit tmo;
    rom_clear();
    rom[0] = mk(2'd1, 32'h20, 32'h1, 32'h1);
    rom[1] = mk(2'd0, 32'h30, 32'h77, 0);
    do_reset();
    rd_seq = '{32'h0, 32'h0, 32'h0, 32'h1};
    pulse_start();
    wait_idle(300, tmo);
    n_chk++; if (tmo) begin n_fail++;
      $display("FAIL poll timeout: busy stuck got 1 exp 0"); end
    n_chk++; if (ar_log.size() != 4) begin n_fail++;
      $display("FAIL poll reads: got %0d exp 4", ar_log.size()); end
    foreach (ar_log[i]) begin
      n_chk++; if (ar_log[i] !== 32'h20) begin n_fail++;
        $display("FAIL poll araddr[%0d]: got %h exp 20", i, ar_log[i]); end
    end
    n_chk++; if (aw_log.size() != 1 || done_cnt != 1) begin n_fail++;
      $display("FAIL poll next cmd: got aw %0d done %0d exp 1/1",
        aw_log.size(), done_cnt); end
  endtask

  task automatic test_delay();
    int n_tab [4];
    bit tmo;
    n_tab = '{10, 0, 1, int'($urandom_range(2, 20))};
    foreach (n_tab[k]) begin
      rom_clear();
      rom[0] = mk(2'd2, 0, n_tab[k], 0);
      rom[1] = mk(2'd0, 32'h8, 32'h9, 0);
      do_reset();
      pulse_start();
      wait_idle(200, tmo);
      // FETCH/DECODE of the delay, N delay cycles, FETCH/DECODE of write
      n_chk++; if (tmo || first_aw - busy_rise != 4 + n_tab[k]) begin
        n_fail++; $display("FAIL delay %0d aw latency: got %0d exp %0d",
          n_tab[k], first_aw - busy_rise, 4 + n_tab[k]); end
    end
  endtask

  task automatic test_bresp_err();
    bit tmo;
    int d0;
    rom_clear();
    for (int i = 0; i < 4; i++) rom[i] = mk(2'd0, 32'h100 + 4 * i, i, 0);
    do_reset();
    err_b_idx = 3;
    pulse_start();
    wait_idle(300, tmo);
    n_chk++; if (tmo || err !== 1 || err_pc !== 4'd3) begin n_fail++;
      $display("FAIL berr: got err %b pc %0d exp 1/3", err, err_pc); end
    n_chk++; if (done_cnt != 0) begin n_fail++;
      $display("FAIL berr done: got %0d exp 0", done_cnt); end
    repeat (3) @(negedge clk);
    n_chk++; if (err !== 1 || busy !== 0) begin n_fail++;
      $display("FAIL berr sticky: got err %b busy %b exp 1/0", err, busy); end
    err_b_idx = -1;
    d0 = aw_log.size();
    pulse_start();
    n_chk++; if (err !== 0 || busy !== 1) begin n_fail++;
      $display("FAIL berr restart: got err %b busy %b exp 0/1", err, busy); end
    wait_idle(300, tmo);
    n_chk++; if (tmo || done_cnt != 1 || aw_log.size() != d0 + 4) begin
      n_fail++; $display("FAIL berr rerun: got done %0d aw %0d exp 1/%0d",
        done_cnt, aw_log.size(), d0 + 4); end
    else begin
      n_chk++; if (aw_log[d0] !== 32'h100) begin n_fail++;
        $display("FAIL berr pc0: got %h exp 100", aw_log[d0]); end
    end
  endtask

  task automatic test_pc_wrap();
    bit tmo;
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(2'd0, 4 * i, i, 0);
    do_reset();
    pulse_start();
    wait_idle(1000, tmo);
    n_chk++; if (tmo || err !== 1 || err_pc !== 4'(DEPTH - 1)) begin
      n_fail++; $display("FAIL wrap: got err %b pc %0d exp 1/%0d",
        err, err_pc, DEPTH - 1); end
    n_chk++; if (aw_log.size() != DEPTH - 1 || done_cnt != 0) begin
      n_fail++; $display("FAIL wrap writes: got %0d done %0d exp %0d/0",
        aw_log.size(), done_cnt, DEPTH - 1); end
  endtask

  task automatic test_random();
    logic [31:0] exp_aw[$], exp_w[$];
    int exp_ar;
    bit tmo;
    for (int it = 0; it < 12; it++) begin
      int n;
      rom_clear();
      do_reset();
      exp_aw.delete(); exp_w.delete(); exp_ar = 0;
      aw_hold = $urandom_range(1, 3);
      w_hold = $urandom_range(1, 3);
      ar_hold = $urandom_range(1, 3);
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
        int op;
        logic [31:0] a, d, m;
        op = $urandom_range(0, 2);
        a = $urandom & 32'hFFFC;
        d = $urandom;
        m = $urandom | 32'h1;
        if (op == 0) begin
          exp_aw.push_back(a); exp_w.push_back(d);
          rom[i] = mk(2'd0, a, d, 0);
        end else if (op == 1) begin
          int k;
          k = $urandom_range(0, 2);
          for (int j = 0; j < k; j++) rd_seq.push_back(d ^ m);
          rd_seq.push_back(d ^ (~m & $urandom));
          exp_ar += k + 1;
          rom[i] = mk(2'd1, a, d, m);
        end else begin
          rom[i] = mk(2'd2, 0, $urandom_range(0, 5), 0);
        end
      end
      pulse_start();
      wait_idle(2000, tmo);
      n_chk++; if (tmo || done_cnt != 1 || err !== 0) begin n_fail++;
        $display("FAIL rnd%0d status: got done %0d err %b exp 1/0",
          it, done_cnt, err); end
      n_chk++; if (ar_log.size() != exp_ar || viol != 0) begin n_fail++;
        $display("FAIL rnd%0d reads/viol: got %0d/%0d exp %0d/0",
          it, ar_log.size(), viol, exp_ar); end
      n_chk++; if (aw_log.size() != exp_aw.size()) begin n_fail++;
        $display("FAIL rnd%0d writes: got %0d exp %0d",
          it, aw_log.size(), exp_aw.size()); end
      else foreach (exp_aw[i]) begin
        n_chk++;
        if (aw_log[i] !== exp_aw[i] || w_log[i] !== exp_w[i]) begin
          n_fail++; $display("FAIL rnd%0d wr%0d: got %h=%h exp %h=%h",
            it, i, aw_log[i], w_log[i], exp_aw[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_rd();
    int n = 0;
    rom_clear();
    rom[0] = mk(2'd1, 32'h20, 1, 1);
    do_reset();
    ar_hold = 1000;
    pulse_start();
    while (!arvalid && n < 20) begin @(negedge clk); n++; end
    n_chk++; if (arvalid !== 1) begin n_fail++;
      $display("FAIL rstrd arvalid: got %b exp 1", arvalid); end
    rst_i = 1;
    @(negedge clk);
    n_chk++; if (arvalid !== 0 || busy !== 0) begin n_fail++;
      $display("FAIL rstrd clear: got arvalid %b busy %b exp 0/0",
        arvalid, busy); end
    rst_i = 0;
  endtask

`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
  task automatic test_poll_timeout();
    bit tmo;
    rom_clear();
    rom[0] = mk(2'd0, 32'h4, 1, 0);
    rom[1] = mk(2'd0, 32'h8, 2, 0);
    rom[2] = mk(2'd1, 32'h20, 1, 1);
    do_reset();
    pulse_start();
    wait_idle(500, tmo);
    n_chk++; if (tmo || ar_log.size() != 4) begin n_fail++;
      $display("FAIL ptmo reads: got %0d exp 4", ar_log.size()); end
    n_chk++; if (err !== 1 || err_pc !== 4'd2 || done_cnt != 0) begin
      n_fail++; $display("FAIL ptmo err: got %b pc %0d exp 1/2", err, err_pc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_aw_delay();
    test_poll();
    test_delay();
    test_bresp_err();
    test_pc_wrap();
    test_random();
    test_reset_mid_rd();
`ifdef AXIL_CMD_SEQ_TIMEOUT_EN
    test_poll_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
